vu_level_meter: RTL and testbench
=================================

# vu_level_meter

Converts a stream of signed audio samples into a frame-stable bar height and peak-hold marker for the VU meter display. It sits directly upstream of `vga_top`, and `vga_top` draws the bar from the `level` and `peak` outputs. Internally the block measures the peak magnitude over fixed sample windows, applies instant attack with timed decay, and adds a peak-hold indicator. Outputs change only on the `frame_start` pulse (start of vertical blanking), so the picture never tears mid-frame.

## Interface
- `SAMPLE_W`, default 12: sample width, two's complement.
- `WINDOW`, default 256: accepted samples per measurement window (≥2).
- `LEVELS`, default 16: number of bar segments; power of two, ≤ 2^(SAMPLE_W-1).
- `DECAY_FRAMES`, default 2: frames per one-segment decay step of the bar (≥1).
- `HOLD_FRAMES`, default 30: frames the peak marker holds before falling.

Ports:
- `clk`  in  1: system clock; all state on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `sample_valid`  in  1: `sample` is accepted on this cycle.
- `sample`  in  SAMPLE_W: signed audio sample.
- `frame_start`  in  1: one-cycle pulse from the display timing at start of vertical blanking.
- `level`  out  clog2(LEVELS+1): displayed bar height, 0..LEVELS.
- `peak`  out  clog2(LEVELS+1): displayed peak-hold segment, 0..LEVELS, always ≥ `level`.
- `update`  out  1: one-cycle pulse, high the cycle after `level` and `peak` are latched.

## Operation
- **Magnitude:** abs = |sample|. The most negative value saturates to 2^(SAMPLE_W-1)-1.
- **Quantise:** SH = SAMPLE_W-1-log2(LEVELS). q = 0 if abs = 0, else ((abs-1) >> SH) + 1. With defaults, 0→0, 1..128→1, 129..256→2, 1921..2047→16.
- **Window:**
  - Sample counter runs 0..WINDOW-1 and advances only on `sample_valid`.
  - The running max of q resets to 0 after each window.
  - On the accepted sample with count = WINDOW-1, the window result wq = max(running max, q of this sample). The counter then wraps to 0.
- **Bar register `bar`:**
  - Decay counter advances on each `frame_start`. On the `frame_start` where it equals DECAY_FRAMES-1, it wraps to 0 and a decay step applies: bar_d = bar-1, floored at 0. Otherwise bar_d = bar.
  - bar_next = max(wq, bar_d) when a window completes this cycle, else bar_d.
  - Window completion and a decay step in the same cycle are both honoured in this one expression.
- **Peak register `pk` with hold counter:**
  - If bar_next > pk: pk ← bar_next and hold ← HOLD_FRAMES. This applies on any cycle.
  - Else, on `frame_start`: if hold ≠ 0 then hold ← hold-1; else if pk > bar_next then pk ← pk-1.
  - pk never falls below bar_next.
- **Output latch:** on `frame_start`, `level` ← bar_next and `peak` ← pk_next, the values this cycle produces. Outputs are otherwise held.
- `sample_valid` without `frame_start` never changes the outputs.

## Timing
- Reset (`rst` low, asynchronous): `level`=0, `peak`=0, `update`=0, and bar, pk, hold, both counters and running max = 0. Leaving reset is synchronous to the next clock edge.
- Reset mid-window discards the partial window. Counting restarts from 0.
- Sample to internal bar: 0 cycles. The bar updates on the same edge that accepts the window's last sample.
- Internal to outputs: outputs latch on the `frame_start` edge. `update` pulses on the following cycle.
- `frame_start` on the same cycle as the window's last sample: outputs include that window.
- Back-to-back `sample_valid` on every cycle is supported with no stall. There is no backpressure.

## Test plan
- **Reset:** assert `rst`=0 mid-stream → `level`=0, `peak`=0, `update`=0 immediately. After release, the first window result counts only post-reset samples.
- **Full scale:** 256 samples of +2047, then `frame_start` → `level`=16, `peak`=16, `update` pulse one cycle later. Repeat with all samples −2048 → 16. A window whose max is −129 → 2; a window of all zeros → 0.
- **Decay:** reach bar 16, then feed zero windows. With DECAY_FRAMES=2, `level` reads 16,15,15,14,… across successive frame_starts (decay on the 2nd, 4th, … frame_start after reset).
- **Peak hold:** after `peak`=16 with `level` decaying, `peak` stays 16 for 30 frame_starts, then drops 1 per frame_start, never below `level`. A new window at 12 while peak is falling at 10 → `peak`=12 with hold reloaded.
- **Collision:** bar=10 with window completion and a decay-step `frame_start` in the same cycle. wq=9 → `level`=9; wq=12 → `level`=12.
- **Window boundary:** a single +2047 sample at index 255 of a window of zeros → 16. The same sample at index 0 of the next window is not counted in the previous window.

Source files
------------

// File: rtl/vu_level_meter.sv
// vu_level_meter
//   Turns a stream of signed audio samples into a bar height and a peak-hold
//   marker for the VU display. Each window of WINDOW accepted samples yields
//   the largest quantised magnitude seen. The bar attacks instantly to that
//   value and decays one segment every DECAY_FRAMES frames. The peak marker
//   holds for HOLD_FRAMES frames, then falls one segment per frame, and never
//   sits below the bar. The displayed values change only on frame_start, so
//   the picture never tears mid-frame.
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst          asynchronous active-low reset
//   sample_valid sample is accepted this cycle
//   sample       signed (two's complement) audio sample
//   frame_start  one-cycle pulse at the start of vertical blanking
//   level        displayed bar height, 0..LEVELS
//   peak         displayed peak-hold segment, 0..LEVELS, always >= level
//   update       one-cycle pulse the cycle after level/peak are latched
module vu_level_meter #(
  parameter int SAMPLE_W     = 12,
  parameter int WINDOW       = 256,
  parameter int LEVELS       = 16,
  parameter int DECAY_FRAMES = 2,
  parameter int HOLD_FRAMES  = 30
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sample_valid,
  input  logic signed [SAMPLE_W-1:0]       sample,
  input  logic                             frame_start,
  output logic [$clog2(LEVELS+1)-1:0]      level,
  output logic [$clog2(LEVELS+1)-1:0]      peak,
  output logic                             update
);

  localparam int LW = $clog2(LEVELS + 1);
  localparam int MW = SAMPLE_W - 1;
  localparam int SH = SAMPLE_W - 1 - $clog2(LEVELS);
  localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int DW = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
  localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  // State
  logic [CW-1:0] cnt;       // sample index inside the current window
  logic [LW-1:0] run_max;   // largest q seen so far in this window
  logic [DW-1:0] dcnt;      // frame_starts since the last decay step
  logic [LW-1:0] bar;
  logic [LW-1:0] pk;
  logic [HW-1:0] hold;

  // Combinational
  logic [SAMPLE_W-1:0] neg;
  logic [MW-1:0]       mag;
  logic [MW-1:0]       mag_m1;
  logic [MW-1:0]       mag_sh;
  logic [LW-1:0]       q;
  logic [LW-1:0]       wq;
  logic                win_done;
  logic                decay_step;
  logic [LW-1:0]       bar_d;
  logic [LW-1:0]       bar_next;
  logic [LW-1:0]       pk_next;
  logic [HW-1:0]       hold_next;

  // Magnitude and quantisation. Negating the most negative code overflows
  // back to itself (MSB still set); that case saturates to full scale.
  always_comb begin
    neg = -sample;
    if (!sample[SAMPLE_W-1])
      mag = sample[MW-1:0];
    else if (neg[SAMPLE_W-1])
      mag = '1;
    else
      mag = neg[MW-1:0];

    // (mag-1)>>SH + 1 puts each segment boundary on an exact multiple of
    // the segment size, so full scale lands on LEVELS rather than LEVELS+1.
    mag_m1 = mag - MW'(1);
    mag_sh = mag_m1 >> SH;
    q      = (mag == '0) ? '0 : LW'(mag_sh) + LW'(1);
  end

  // Window result, decay and attack for the bar.
  always_comb begin
    win_done   = sample_valid && (cnt == CW'(WINDOW - 1));
    wq         = (q > run_max) ? q : run_max;
    decay_step = frame_start && (dcnt == DW'(DECAY_FRAMES - 1));
    bar_d      = (decay_step && (bar != '0)) ? bar - LW'(1) : bar;
    // A completing window and a decay step on the same edge both apply here.
    bar_next   = (win_done && (wq > bar_d)) ? wq : bar_d;
  end

  // Peak-hold marker. A rise above the marker can happen on any cycle and
  // reloads the hold time; holding and falling only advance on frame_start.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    pk_next   = pk;
    hold_next = hold;
    if (bar_next > pk) begin
      pk_next   = bar_next;
      hold_next = HW'(HOLD_FRAMES);
    end else if (frame_start) begin
      if (hold != '0)
        hold_next = hold - HW'(1);
      else if (pk > bar_next)
        pk_next = pk - LW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      run_max <= '0;
      dcnt    <= '0;
      bar     <= '0;
      pk      <= '0;
      hold    <= '0;
      level   <= '0;
      peak    <= '0;
      update  <= 1'b0;
    end else begin
      if (sample_valid) begin
        if (win_done) begin
          cnt     <= '0;
          run_max <= '0;
        end else begin
          cnt     <= cnt + CW'(1);
          run_max <= wq;
        end
      end

      if (frame_start)
        dcnt <= decay_step ? '0 : dcnt + DW'(1);

      bar    <= bar_next;
      pk     <= pk_next;
      hold   <= hold_next;
      update <= frame_start;

      // Display values only move at the start of blanking.
      if (frame_start) begin
        level <= bar_next;
        peak  <= pk_next;
      end
    end
  end

endmodule

// File: tb/tb_vu_level_meter.sv
// Self-checking bench for vu_level_meter with default parameters.
module tb_vu_level_meter;

  localparam int SW     = 12;
  localparam int WINDOW = 256;
  localparam int LEVELS = 16;
  localparam int DECAY  = 2;
  localparam int HOLD   = 30;
  localparam int LW     = $clog2(LEVELS + 1);
  localparam int MAXMAG = 2 ** (SW - 1) - 1;
  localparam int STEP   = (MAXMAG + 1) / LEVELS;

  logic                 clk;
  logic                 rst;
  logic                 sample_valid;
  logic signed [SW-1:0] sample;
  logic                 frame_start;
  logic [LW-1:0]        level;
  logic [LW-1:0]        peak;
  logic                 update;

  int errors = 0;
  int checks = 0;

  vu_level_meter #(
    .SAMPLE_W    (SW),
    .WINDOW      (WINDOW),
    .LEVELS      (LEVELS),
    .DECAY_FRAMES(DECAY),
    .HOLD_FRAMES (HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .sample      (sample),
    .frame_start (frame_start),
    .level       (level),
    .peak        (peak),
    .update      (update)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model (plain integer arithmetic) -------------
  int win_q[$];     // q values of the samples accepted in the open window
  int m_frames;     // frame_starts since reset
  int m_bar, m_pk, m_hold, m_level, m_peak;
  bit m_update;

  function automatic int qval(int s);
    int a;
    a = (s < 0) ? -s : s;
    if (a > MAXMAG) a = MAXMAG;
    if (a == 0) return 0;
    return (a - 1) / STEP + 1;
  endfunction

  function automatic void model_reset();
    win_q.delete();
    m_frames = 0;
    m_bar = 0; m_pk = 0; m_hold = 0; m_level = 0; m_peak = 0;
    m_update = 1'b0;
  endfunction

  function automatic void model_step(bit sv, int s, bit fs);
    int wq, bar_d, bn;
    bit done;
    wq = 0;
    done = 1'b0;
    if (sv) begin
      win_q.push_back(qval(s));
      if (win_q.size() == WINDOW) begin
        foreach (win_q[i]) if (win_q[i] > wq) wq = win_q[i];
        done = 1'b1;
        win_q.delete();
      end
    end
    bar_d = m_bar;
    if (fs) begin
      m_frames++;
      if (m_frames % DECAY == 0) bar_d = (m_bar > 0) ? m_bar - 1 : 0;
    end
    bn = (done && wq > bar_d) ? wq : bar_d;
    if (bn > m_pk) begin
      m_pk = bn;
      m_hold = HOLD;
    end else if (fs) begin
      if (m_hold > 0) m_hold--;
      else if (m_pk > bn) m_pk--;
    end
    m_bar = bn;
    m_update = fs;
    if (fs) begin
      m_level = bn;
      m_peak = m_pk;
    end
  endfunction

  // ---------------- stimulus helpers (called at a falling edge) ------------
  task automatic tick(input bit sv, input logic signed [SW-1:0] s, input bit fs);
    sample_valid = sv;
    sample       = s;
    frame_start  = fs;
    @(posedge clk);
    model_step(sv, int'(s), fs);
    @(negedge clk);
    sample_valid = 1'b0;
    frame_start  = 1'b0;
  endtask

  task automatic feed(input int n, input logic signed [SW-1:0] s);
    for (int i = 0; i < n; i++) tick(1'b1, s, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sample_valid = 1'b0;
    frame_start = 1'b0;
    sample = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // ---------------- tests --------------------------------------------------
  task automatic test_reset();
    do_reset();
    if (level !== 0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++;
    if (peak !== 0) begin errors++; $display("FAIL reset_peak: got %0d expected 0", peak); end
    checks++;
    if (update !== 1'b0) begin errors++; $display("FAIL reset_update: got %0b expected 0", update); end
    checks++;

    // Fill the display, leave a half window pending, then reset mid-cycle.
    feed(WINDOW, 12'sd2047);
    feed(WINDOW / 2, 12'sd2047);
    tick(1'b0, '0, 1'b1);
    if (level !== 16) begin errors++; $display("FAIL pre_reset_level: got %0d expected 16", level); end
    checks++;
    #2 rst = 1'b0;
    #1;
    if (level !== 0 || peak !== 0 || update !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got level=%0d peak=%0d update=%0b expected 0/0/0", level, peak, update);
    end
    checks++;
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // First window after reset must hold only post-reset samples (q=2).
    feed(WINDOW, 12'sd200);
    tick(1'b0, '0, 1'b1);
    if (level !== 2) begin errors++; $display("FAIL post_reset_window: got %0d expected 2", level); end
    checks++;
  endtask

  task automatic test_full_scale();
    logic signed [SW-1:0] s;
    do_reset();
    feed(WINDOW, 12'sd2047);
    if (level !== 0 || update !== 1'b0) begin
      errors++;
      $display("FAIL hold_until_frame: got level=%0d update=%0b expected 0/0", level, update);
    end
    checks++;
    tick(1'b0, '0, 1'b1);
    if (level !== 16 || peak !== 16) begin
      errors++;
      $display("FAIL full_pos: got level=%0d peak=%0d expected 16/16", level, peak);
    end
    checks++;
    if (update !== 1'b1) begin errors++; $display("FAIL update_pulse: got %0b expected 1", update); end
    checks++;
    tick(1'b0, '0, 1'b0);
    if (update !== 1'b0) begin errors++; $display("FAIL update_single: got %0b expected 0", update); end
    checks++;

    do_reset();
    feed(WINDOW, -12'sd2048);
    tick(1'b0, '0, 1'b1);
    if (level !== 16) begin errors++; $display("FAIL full_neg: got %0d expected 16", level); end
    checks++;

    do_reset();
    for (int i = 0; i < WINDOW; i++) begin
      s = (i == 100) ? -12'sd129 : SW'($signed($urandom_range(256)) - 128);
      tick(1'b1, s, 1'b0);
    end
    tick(1'b0, '0, 1'b1);
    if (level !== 2) begin errors++; $display("FAIL neg_129: got %0d expected 2", level); end
    checks++;

    do_reset();
    feed(WINDOW, '0);
    tick(1'b0, '0, 1'b1);
    if (level !== 0 || peak !== 0) begin
      errors++;
      $display("FAIL zero_window: got level=%0d peak=%0d expected 0/0", level, peak);
    end
    checks++;
  endtask

  task automatic test_decay_peak_hold();
    int exp_l, exp_p;
    do_reset();
    feed(WINDOW, 12'sd2047);
    for (int k = 1; k <= 36; k++) begin
      tick(1'b0, '0, 1'b1);
      exp_l = 16 - k / 2;
      if (exp_l < 0) exp_l = 0;
      exp_p = (k <= HOLD) ? 16 : 16 - (k - HOLD);
      if (exp_p < exp_l) exp_p = exp_l;
      if (level !== exp_l) begin errors++; $display("FAIL decay_level f%0d: got %0d expected %0d", k, level, exp_l); end
      checks++;
      if (peak !== exp_p) begin errors++; $display("FAIL hold_peak f%0d: got %0d expected %0d", k, peak, exp_p); end
      checks++;
      tick(1'b0, '0, 1'b0);
      tick(1'b0, '0, 1'b0);
    end

    // Peak is falling at 10; a window at 12 lifts it and reloads the hold.
    feed(WINDOW, 12'sd1500);
    for (int k = 37; k <= 67; k++) begin
      tick(1'b0, '0, 1'b1);
      exp_l = 12 - (k - 36) / 2;
      if (exp_l < 0) exp_l = 0;
      exp_p = (k <= 36 + HOLD) ? 12 : 11;
      if (level !== exp_l) begin errors++; $display("FAIL redecay_level f%0d: got %0d expected %0d", k, level, exp_l); end
      checks++;
      if (peak !== exp_p) begin errors++; $display("FAIL rehold_peak f%0d: got %0d expected %0d", k, peak, exp_p); end
      checks++;
      tick(1'b0, '0, 1'b0);
    end
  endtask

  task automatic test_collision();
    // wq=9 against bar 10 decaying to 9 on the same edge.
    do_reset();
    feed(WINDOW, 12'sd1200);
    tick(1'b0, '0, 1'b1);
    if (level !== 10) begin errors++; $display("FAIL collide_setup: got %0d expected 10", level); end
    checks++;
    feed(WINDOW - 1, 12'sd1100);
    tick(1'b1, 12'sd1100, 1'b1);
    if (level !== 9 || peak !== 10) begin
      errors++;
      $display("FAIL collide_low: got level=%0d peak=%0d expected 9/10", level, peak);
    end
    checks++;

    // wq=12 wins over the decay step.
    do_reset();
    feed(WINDOW, 12'sd1200);
    tick(1'b0, '0, 1'b1);
    feed(WINDOW - 1, 12'sd1500);
    tick(1'b1, 12'sd1500, 1'b1);
    if (level !== 12 || peak !== 12) begin
      errors++;
      $display("FAIL collide_high: got level=%0d peak=%0d expected 12/12", level, peak);
    end
    checks++;
  endtask

  task automatic test_window_boundary();
    do_reset();
    feed(WINDOW - 1, '0);
    tick(1'b1, 12'sd2047, 1'b0);
    tick(1'b0, '0, 1'b1);
    if (level !== 16) begin errors++; $display("FAIL last_index: got %0d expected 16", level); end
    checks++;

    do_reset();
    feed(WINDOW, '0);
    tick(1'b0, '0, 1'b1);
    tick(1'b1, 12'sd2047, 1'b1);
    if (level !== 0) begin errors++; $display("FAIL next_index0: got %0d expected 0", level); end
    checks++;
    feed(WINDOW - 1, '0);
    tick(1'b0, '0, 1'b1);
    if (level !== 16) begin errors++; $display("FAIL index0_counted: got %0d expected 16", level); end
    checks++;
  endtask

  task automatic test_random();
    int amp;
    bit sv, fs;
    logic signed [SW-1:0] s;
    do_reset();
    amp = 2048;
    for (int i = 0; i < 6000; i++) begin
      if (i % 400 == 0) amp = 1 << $urandom_range(11);
      sv = ($urandom_range(3) != 0);
      fs = ($urandom_range(29) == 0);
      s  = SW'($signed($urandom_range(2 * amp - 1)) - amp);
      tick(sv, s, fs);
      if (level !== LW'(m_level) || peak !== LW'(m_peak) || update !== m_update) begin
        errors++;
        $display("FAIL random c%0d: got level=%0d peak=%0d update=%0b expected %0d/%0d/%0b",
                 i, level, peak, update, m_level, m_peak, m_update);
      end
      checks++;
      if (peak < level) begin
        errors++;
        $display("FAIL peak_ge_level c%0d: got peak=%0d level=%0d", i, peak, level);
      end
      checks++;
    end
  endtask

  initial begin
    rst = 1'b0;
    sample_valid = 1'b0;
    sample = '0;
    frame_start = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_full_scale();
    test_decay_peak_hold();
    test_collision();
    test_window_boundary();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
